// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART txd line between NUM_PORTS
// byte-stream requesters. Each granted byte goes out as an 8N1 frame, LSB first, with
// dbr clocks per bit. A new grant needs the synchronized cts to be high.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between data and stop.
module uart_tx_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DBR_WIDTH  = 32
) (
  input  logic                            clock10M,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [DBR_WIDTH-1:0]            dbr,
  input  logic                            cts,
  output logic                            txd,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int unsigned IdW  = $clog2(NUM_PORTS);
  localparam int unsigned BitW = $clog2(DATA_WIDTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e                  state_q, state_d;
  logic                    cts_meta_q, cts_s_q;
  logic [IdW-1:0]          ptr_q, ptr_d;
  logic [IdW-1:0]          grant_q, grant_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [DBR_WIDTH-1:0]    period_q, period_d;
  logic [DBR_WIDTH-1:0]    cnt_q, cnt_d;
  logic [BitW-1:0]         bitcnt_q, bitcnt_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic                    found_hi, found_lo, arb_found;
  logic [IdW-1:0]          win_hi, win_lo, arb_win, ptr_next;
  logic [DATA_WIDTH-1:0]   arb_data;
  logic                    bit_done;
  logic                    grant_now;

  // Two-flop synchronizer for the asynchronous cts input
  always_ff @(posedge clock10M or negedge reset) begin
    if (!reset) begin
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
    end else begin
      cts_meta_q <= cts;
      cts_s_q    <= cts_meta_q;
    end
  end

  // Round-robin pick: first valid port at or above the pointer, else first valid overall
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (!found_hi && req_valid[p] && (p >= 32'(ptr_q))) begin
        found_hi = 1'b1;
        win_hi   = IdW'(p);
      end
      if (!found_lo && req_valid[p]) begin
        found_lo = 1'b1;
        win_lo   = IdW'(p);
      end
    end
    arb_found = found_hi | found_lo;
    arb_win   = found_hi ? win_hi : win_lo;
    ptr_next  = (32'(arb_win) == NUM_PORTS - 1) ? '0 : arb_win + IdW'(1);
    arb_data  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (IdW'(p) == arb_win) begin
        arb_data = req_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake strobe: only from IDLE with cts_s high, purely from req_valid/pointer/state
  always_comb begin
    grant_now = (state_q == StIdle) && cts_s_q && arb_found;
    req_ready = '0;
    if (grant_now) begin
      req_ready[arb_win] = 1'b1;
    end
  end

  // Next-state and datapath updates for the frame sequencer
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    shreg_d  = shreg_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_done = (cnt_q == period_q - DBR_WIDTH'(1));

    // Bit-period counter runs 0..period-1 in every non-idle state
    if (state_q != StIdle) begin
      cnt_d = bit_done ? '0 : cnt_q + DBR_WIDTH'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (grant_now) begin
          state_d  = StStart;
          grant_d  = arb_win;
          ptr_d    = ptr_next;
          shreg_d  = arb_data;
          period_d = (dbr == '0) ? DBR_WIDTH'(1) : dbr;
          cnt_d    = '0;
          bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^arb_data;
`endif
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + BitW'(1);
          if (bitcnt_q == BitW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight byte
  always_ff @(posedge clock10M or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      shreg_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      bitcnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      shreg_q  <= shreg_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Line driver decoded from state so async reset forces txd high immediately
  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      StStart:  txd = 1'b0;
      StData:   txd = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      StParity: txd = parity_q;
`endif
      default:  txd = 1'b1;
    endcase
    busy     = (state_q != StIdle);
    grant_id = grant_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_PORTS=2).
module tb_uart_tx_arbiter;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [31:0] dbr;
  logic        cts;
  logic        txd;
  logic [0:0]  grant_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(
    .NUM_PORTS (2),
    .DATA_WIDTH(8),
    .DBR_WIDTH (32)
  ) dut (
    .clock10M (clk),
    .reset    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .dbr      (dbr),
    .cts      (cts),
    .txd      (txd),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at cycle 0 of START; checks every cycle of the frame and the idle cycle after it
  task automatic check_frame(input logic [7:0] data, input int per, input string tag);
    logic [10:0] fr;
    logic [10:0] sh;
`ifdef UART_TX_PARITY_EN
    fr = {1'b1, ^data, data, 1'b0};
`else
    fr = {1'b0, 1'b1, data, 1'b0};
`endif
    for (int j = 0; j < NB * per; j++) begin
      sh = fr >> (j / per);
      chk({tag, "_txd"}, txd, sh[0]);
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_ready"}, req_ready, 2'b00);
      step();
    end
    chk({tag, "_end_busy"}, busy, 1'b0);
    chk({tag, "_end_txd"}, txd, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b1;
    cts       = 1'b1;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    dbr       = 32'd4;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_grant", grant_id, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("idle_txd", txd, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", req_ready, 2'b00);

    // Port 0 sends 0xA5 at 4 clocks per bit
    req_data[7:0] = 8'hA5;
    req_valid     = 2'b01;
    #1;
    chk("t1_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("t1_grant", grant_id, 1'b0);
    check_frame(8'hA5, 4, "t1");
    chk("t1_grant_after", grant_id, 1'b0);

    // Both ports valid, dbr=1; pointer sits at 1 after the previous grant
    dbr       = 32'd1;
    req_data  = 16'h2211;
    req_valid = 2'b11;
    #1;
    chk("t2_ready_a", req_ready, 2'b10);
    step();
    chk("t2_grant_a", grant_id, 1'b1);
    check_frame(8'h22, 1, "t2a");
    chk("t2_ready_b", req_ready, 2'b01);
    step();
    chk("t2_grant_b", grant_id, 1'b0);
    check_frame(8'h11, 1, "t2b");
    chk("t2_ready_c", req_ready, 2'b10);
    step();
    chk("t2_grant_c", grant_id, 1'b1);
    check_frame(8'h22, 1, "t2c");
    chk("t2_ready_d", req_ready, 2'b01);
    step();
    chk("t2_grant_d", grant_id, 1'b0);
    check_frame(8'h11, 1, "t2d");
    req_valid = 2'b00;

    // cts gating and synchronizer delay; pointer at 1
    cts = 1'b0;
    step();
    step();
    req_data[15:8] = 8'h3C;
    req_valid      = 2'b10;
    #1;
    chk("t3_blocked_ready", req_ready, 2'b00);
    chk("t3_blocked_txd", txd, 1'b1);
    chk("t3_blocked_busy", busy, 1'b0);
    step();
    chk("t3_blocked_ready2", req_ready, 2'b00);
    cts = 1'b1;
    step();
    chk("t3_sync1_ready", req_ready, 2'b00);
    step();
    chk("t3_sync2_ready", req_ready, 2'b10);
    step();
    cts = 1'b0;
    chk("t3_grant", grant_id, 1'b1);
    check_frame(8'h3C, 1, "t3");
    chk("t3_after_ready", req_ready, 2'b00);
    step();
    chk("t3_after_ready2", req_ready, 2'b00);
    chk("t3_after_busy", busy, 1'b0);
    req_valid = 2'b00;

    // dbr=0 treated as 1; dbr change mid-frame applies to the next frame
    cts = 1'b1;
    step();
    step();
    req_data[7:0] = 8'hFF;
    req_valid     = 2'b01;
    dbr           = 32'd0;
    #1;
    chk("t4_ready_a", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    dbr       = 32'd3;
    chk("t4_grant_a", grant_id, 1'b0);
    check_frame(8'hFF, 1, "t4a");
    req_data[7:0] = 8'h5A;
    req_valid     = 2'b01;
    #1;
    chk("t4_ready_b", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    check_frame(8'h5A, 3, "t4b");

    // Reset during data bit 3 of 0x96 at dbr=2; pointer at 1
    dbr            = 32'd2;
    req_data[15:8] = 8'h96;
    req_valid      = 2'b10;
    #1;
    chk("t5_ready", req_ready, 2'b10);
    step();
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) step();
    chk("t5_bit3_txd", txd, 1'b0);
    chk("t5_bit3_busy", busy, 1'b1);
    chk("t5_bit3_grant", grant_id, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_txd", txd, 1'b1);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_ready", req_ready, 2'b00);
    chk("t5_rst_grant", grant_id, 1'b0);
    #2 rst_n = 1'b1;
    step();
    chk("t5_sync1_ready", req_ready, 2'b00);
    step();
    chk("t5_sync2_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    chk("t5_grant", grant_id, 1'b0);
    check_frame(8'h5A, 2, "t5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
